// File: rtl/bcd_display_scanner.sv
// Buffers one packed BCD word behind valid/ready and multiplexes its three digits
// onto a shared 7-segment bus, with ghost blanking, leading-zero suppression and an error flag.
module bcd_display_scanner #(
    parameter int REFRESH_DIV    = 1000,
    parameter int BLANK_CYCLES   = 2,
    parameter int SEG_ACTIVE_LOW = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] bcd_in,
    input  logic        bcd_valid,
    output logic        bcd_ready,
    input  logic        lz_blank,
    output logic [6:0]  seg,
    output logic [2:0]  anode,
    output logic        digit_err
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0] PHASE_LAST = PW'(REFRESH_DIV - 1);

    logic [11:0]   pend_q, pend_d;
    logic          pend_full_q, pend_full_d;
    logic [11:0]   disp_q, disp_d;
    logic [1:0]    slot_q, slot_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [6:0]    seg_q, seg_d;
    logic [2:0]    anode_q, anode_d;
    logic          err_q, err_d;

    logic          phase_wrap;
    logic          frame_wrap;
    logic [3:0]    nib;
    logic [2:0]    onehot;
    logic          suppress;
    logic          blank;
    logic [31:0]   phase_ext;

    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h40;
        endcase
    endfunction

    always_comb begin
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        disp_d      = disp_q;
        err_d       = err_q;

        phase_wrap = (phase_q == PHASE_LAST);
        frame_wrap = phase_wrap && (slot_q == 2'd2);
        phase_d    = phase_wrap ? '0 : phase_q + 1'b1;
        if (phase_wrap) begin
            slot_d = (slot_q == 2'd2) ? 2'd0 : slot_q + 2'd1;
        end else begin
            slot_d = slot_q;
        end

        // Display only changes between frames so a digit never tears mid-scan.
        if (frame_wrap && pend_full_q) begin
            disp_d      = pend_q;
            pend_full_d = 1'b0;
            err_d       = (pend_q[11:8] > 4'd9) || (pend_q[7:4] > 4'd9) || (pend_q[3:0] > 4'd9);
        end

        if (bcd_valid && !pend_full_q) begin
            pend_d      = bcd_in;
            pend_full_d = 1'b1;
        end

        case (slot_d)
            2'd0: begin
                nib    = disp_d[3:0];
                onehot = 3'b001;
            end
            2'd1: begin
                nib    = disp_d[7:4];
                onehot = 3'b010;
            end
            default: begin
                nib    = disp_d[11:8];
                onehot = 3'b100;
            end
        endcase

        suppress = lz_blank && (disp_d[11:8] == 4'd0) &&
                   ((slot_d == 2'd2) || ((slot_d == 2'd1) && (disp_d[7:4] == 4'd0)));
        phase_ext = 32'(phase_d);
        blank     = (phase_ext < BLANK_CYCLES) || suppress;

        if (blank) begin
            seg_d   = 7'h00;
            anode_d = 3'b000;
        end else begin
            seg_d   = decode(nib);
            anode_d = onehot;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q      <= 12'h000;
            pend_full_q <= 1'b0;
            disp_q      <= 12'h000;
            slot_q      <= 2'd0;
            phase_q     <= '0;
            seg_q       <= 7'h00;
            anode_q     <= 3'b000;
            err_q       <= 1'b0;
        end else begin
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            disp_q      <= disp_d;
            slot_q      <= slot_d;
            phase_q     <= phase_d;
            seg_q       <= seg_d;
            anode_q     <= anode_d;
            err_q       <= err_d;
        end
    end

    assign bcd_ready = !pend_full_q;
    assign digit_err = err_q;
    assign seg       = (SEG_ACTIVE_LOW != 0) ? ~seg_q : seg_q;
    assign anode     = (SEG_ACTIVE_LOW != 0) ? ~anode_q : anode_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Randomized bench for bcd_display_scanner: an absolute-time reference model predicts
// every output of an active-high and an active-low instance driven in parallel.
module tb_bcd_display_scanner;

    localparam int RDIV  = 4;
    localparam int BLANK = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] bcd_in;
    logic        bcd_valid;
    logic        lz_blank;
    logic        bcd_ready, bcd_ready_n;
    logic [6:0]  seg, seg_n;
    logic [2:0]  anode, anode_n;
    logic        digit_err, digit_err_n;

    int checks = 0;
    int errors = 0;

    int          m_t;
    logic        m_full;
    logic [11:0] m_pend;
    logic [11:0] m_disp;
    logic        m_err;
    logic        m_lz;

    logic [6:0]  seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
    logic [11:0] picks [9]    = '{12'h255, 12'h128, 12'h047, 12'h007, 12'h000,
                                  12'h100, 12'h1A3, 12'h123, 12'h009};

    bcd_display_scanner #(.REFRESH_DIV(RDIV), .BLANK_CYCLES(BLANK), .SEG_ACTIVE_LOW(0)) dut (
        .clk(clk), .rst(rst), .bcd_in(bcd_in), .bcd_valid(bcd_valid), .bcd_ready(bcd_ready),
        .lz_blank(lz_blank), .seg(seg), .anode(anode), .digit_err(digit_err)
    );

    bcd_display_scanner #(.REFRESH_DIV(RDIV), .BLANK_CYCLES(BLANK), .SEG_ACTIVE_LOW(1)) dut_n (
        .clk(clk), .rst(rst), .bcd_in(bcd_in), .bcd_valid(bcd_valid), .bcd_ready(bcd_ready_n),
        .lz_blank(lz_blank), .seg(seg_n), .anode(anode_n), .digit_err(digit_err_n)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s at t=%0d: got %h, expected %h", tag, m_t, observed, expected);
        end
    endtask

    task automatic modelReset();
        m_t    = 0;
        m_full = 1'b0;
        m_pend = 12'h000;
        m_disp = 12'h000;
        m_err  = 1'b0;
        m_lz   = 1'b0;
    endtask

    // Advance the model by one rising edge using the inputs that were present at that edge.
    task automatic modelStep(input logic v, input logic [11:0] din, input logic lz);
        logic accept;
        accept = v && !m_full;
        if ((m_t % (3 * RDIV)) == (3 * RDIV - 1) && m_full) begin
            m_disp = m_pend;
            m_full = 1'b0;
            m_err  = (m_pend[11:8] > 9) || (m_pend[7:4] > 9) || (m_pend[3:0] > 9);
        end
        if (accept) begin
            m_pend = din;
            m_full = 1'b1;
        end
        m_lz = lz;
        m_t++;
    endtask

    task automatic compareAll();
        int         phase, slot;
        logic [3:0] nib;
        logic       sup;
        logic [6:0] exp_seg, exp_seg_n;
        logic [2:0] exp_an, exp_an_n;
        phase = m_t % RDIV;
        slot  = (m_t / RDIV) % 3;
        nib   = m_disp[4*slot +: 4];
        sup   = m_lz && (m_disp[11:8] == 0) &&
                (slot == 2 || (slot == 1 && m_disp[7:4] == 0));
        if (phase < BLANK || sup) begin
            exp_seg = 7'h00;
            exp_an  = 3'b000;
        end else begin
            exp_seg = seg_tab[nib];
            exp_an  = 3'(1 << slot);
        end
        exp_seg_n = ~exp_seg;
        exp_an_n  = ~exp_an;
        checkOutput("seg", 32'(seg), 32'(exp_seg));
        checkOutput("anode", 32'(anode), 32'(exp_an));
        checkOutput("digit_err", 32'(digit_err), 32'(m_err));
        checkOutput("bcd_ready", 32'(bcd_ready), 32'(!m_full));
        checkOutput("seg_pins_low", 32'(seg_n), 32'(exp_seg_n));
        checkOutput("anode_pins_low", 32'(anode_n), 32'(exp_an_n));
    endtask

    task automatic applyStimulus();
        logic [3:0] n [3];
        bcd_valid = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 1) == 1) begin
            bcd_in = picks[$urandom_range(0, 8)];
        end else begin
            for (int k = 0; k < 3; k++) begin
                n[k] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 12));
            end
            bcd_in = {n[2], n[1], n[0]};
        end
        if ($urandom_range(0, 15) == 0) lz_blank = ~lz_blank;
    endtask

    // Precondition: called at a falling edge; returns at a falling edge.
    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) begin
            compareAll();
            applyStimulus();
            @(posedge clk);
            modelStep(bcd_valid, bcd_in, lz_blank);
            @(negedge clk);
        end
    endtask

    initial begin
        rst       = 1'b1;
        bcd_in    = 12'h000;
        bcd_valid = 1'b0;
        lz_blank  = 1'b0;
        modelReset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        modelReset();
        runCycles(1500);

        bcd_valid = 1'b0;
        for (int i = 0; i < 100 && !m_full; i++) begin
            runCycles(1);
            bcd_valid = 1'b1;
            bcd_in    = 12'h255;
        end
        bcd_valid = 1'b0;
        checkOutput("ready_low_before_reset", 32'(bcd_ready), 32'(0));

        #1 rst = 1'b1;
        #1;
        checkOutput("rst_seg", 32'(seg), 32'(0));
        checkOutput("rst_anode", 32'(anode), 32'(0));
        checkOutput("rst_ready", 32'(bcd_ready), 32'(1));
        checkOutput("rst_err", 32'(digit_err), 32'(0));
        checkOutput("rst_seg_pins_low", 32'(seg_n), 32'(7'h7F));
        checkOutput("rst_anode_pins_low", 32'(anode_n), 32'(3'b111));
        @(negedge clk);
        rst = 1'b0;
        modelReset();
        runCycles(1500);
        compareAll();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
